// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//   Control core for the 2-digit calculator. Debounces the four active-low
//   push buttons (B1 add, B2 sub, B3 mul, B4 power) and acts on the release
//   of a button. Computes add/sub in one cycle and multiply as a 7-step
//   LSB-first shift-add. Holds the binary result plus status for the
//   display/BCD stage.
//
// Ports
//   clk_i        system clock, all logic on posedge
//   rst_n_i      asynchronous active-low reset
//   b1_i..b4_i   raw buttons, active-low (0 = pressed), asynchronous
//   n1_i, n2_i   operands, legal range 0..99
//   state_o      0 OFF, 1 IDLE, 2 CALC, 3 SHOW
//   op_o         0 none, 1 add, 2 sub, 3 mul
//   result_o     magnitude of the result (max 9801)
//   neg_o        subtraction result negative (A < B)
//   res_valid_o  result_o is current for the latched operands/op
//   busy_o       high while in CALC
//   err_o        a latched operand was > 99
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        b1_i,
  input  logic        b2_i,
  input  logic        b3_i,
  input  logic        b4_i,
  input  logic [6:0]  n1_i,
  input  logic [6:0]  n2_i,
  output logic [1:0]  state_o,
  output logic [1:0]  op_o,
  output logic [13:0] result_o,
  output logic        neg_o,
  output logic        res_valid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_CALC = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  // -------------------------------------------------------------------------
  // Button synchronise + debounce. Index 0..3 = B1..B4.
  // -------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] rel_evt;

  assign btn_raw = {b4_i, b3_i, b2_i, b1_i};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic          deb_q;
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          deb_q   <= 1'b1;
          cnt_q   <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          // Count consecutive disagreeing samples; any agreement restarts.
          if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
              deb_q <= sync2_q;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
      end

      // Release pulse is asserted in the cycle the debounced level is about
      // to go 0->1, so the FSM reacts on the same edge that flips deb_q.
      assign rel_evt[gi] = ~deb_q & sync2_q & (cnt_q == CNT_LAST);
    end
  endgenerate

  // Same-cycle priority: B4 > B1 > B2 > B3; losers are dropped.
  logic       evt_pwr;
  logic [1:0] evt_op;

  always_comb begin
    evt_pwr = rel_evt[3];
    evt_op  = OP_NONE;
    if (!rel_evt[3]) begin
      if (rel_evt[0])      evt_op = OP_ADD;
      else if (rel_evt[1]) evt_op = OP_SUB;
      else if (rel_evt[2]) evt_op = OP_MUL;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath / FSM
  // -------------------------------------------------------------------------
  state_t      state_q;
  logic [1:0]  op_q;
  logic [6:0]  a_q;
  logic [6:0]  b_q;
  logic [13:0] acc_q;
  logic [2:0]  bit_q;
  logic [13:0] result_q;
  logic        neg_q;
  logic        res_valid_q;
  logic        err_q;

  logic [13:0] a_ext;
  logic [13:0] b_ext;
  logic [13:0] mul_sum;
  logic        operand_changed;
  logic        op_err;

  assign a_ext = {7'd0, a_q};
  assign b_ext = {7'd0, b_q};
  // Partial product for the current multiplier bit.
  assign mul_sum = acc_q + (b_q[bit_q] ? (a_ext << bit_q) : 14'd0);
  assign operand_changed = (n1_i != a_q) || (n2_i != b_q);
  assign op_err = (n1_i > 7'd99) || (n2_i > 7'd99);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_OFF;
      op_q        <= OP_NONE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      bit_q       <= '0;
      result_q    <= '0;
      neg_q       <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          result_q <= '0;
          if (evt_pwr) state_q <= ST_IDLE;
        end

        ST_IDLE: begin
          result_q    <= '0;
          res_valid_q <= 1'b0;
          if (evt_pwr) begin
            state_q <= ST_OFF;
            op_q    <= OP_NONE;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
          end else if (evt_op != OP_NONE) begin
            // Operands are latched on entry, so the first CALC cycle
            // already works on A/B.
            state_q     <= ST_CALC;
            op_q        <= evt_op;
            a_q         <= n1_i;
            b_q         <= n2_i;
            err_q       <= op_err;
            acc_q       <= '0;
            bit_q       <= '0;
          end
        end

        ST_CALC, ST_SHOW: begin
          if (evt_pwr) begin
            state_q     <= ST_OFF;
            op_q        <= OP_NONE;
            result_q    <= '0;
            neg_q       <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
          end else if (evt_op != OP_NONE && evt_op == op_q) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NONE;
            result_q    <= '0;
            neg_q       <= 1'b0;
            res_valid_q <= 1'b0;
          end else if (evt_op != OP_NONE ||
                       (state_q == ST_SHOW && operand_changed)) begin
            // New op, or recompute of the current op; an in-flight
            // computation is discarded and result_q keeps its last value.
            state_q     <= ST_CALC;
            op_q        <= (evt_op != OP_NONE) ? evt_op : op_q;
            a_q         <= n1_i;
            b_q         <= n2_i;
            err_q       <= op_err;
            acc_q       <= '0;
            bit_q       <= '0;
            res_valid_q <= 1'b0;
          end else if (state_q == ST_CALC) begin
            case (op_q)
              OP_ADD: begin
                result_q    <= err_q ? 14'd0 : (a_ext + b_ext);
                neg_q       <= 1'b0;
                res_valid_q <= 1'b1;
                state_q     <= ST_SHOW;
              end
              OP_SUB: begin
                result_q    <= err_q ? 14'd0 :
                               ((a_q < b_q) ? (b_ext - a_ext) : (a_ext - b_ext));
                neg_q       <= ~err_q & (a_q < b_q);
                res_valid_q <= 1'b1;
                state_q     <= ST_SHOW;
              end
              OP_MUL: begin
                if (bit_q == 3'd6) begin
                  result_q    <= err_q ? 14'd0 : mul_sum;
                  neg_q       <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= ST_SHOW;
                end else begin
                  acc_q <= mul_sum;
                  bit_q <= bit_q + 3'd1;
                end
              end
              default: begin
                // No op latched: nothing to compute, fall back to IDLE.
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign op_o        = op_q;
  assign result_o    = result_q;
  assign neg_o       = neg_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = (state_q == ST_CALC);
  assign err_o       = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_op_sequencer
//   Self-checking bench for calc_op_sequencer. Expected results are pushed to
//   a scoreboard queue when an operation is started and popped when the DUT
//   raises res_valid_o.
// ---------------------------------------------------------------------------
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn = 4'hF;
  logic [6:0]  n1 = 7'd0;
  logic [6:0]  n2 = 7'd0;
  logic [1:0]  state_o;
  logic [1:0]  op_o;
  logic [13:0] result_o;
  logic        neg_o;
  logic        res_valid_o;
  logic        busy_o;
  logic        err_o;

  calc_op_sequencer #(.DEB_CYCLES(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .b1_i        (btn[0]),
    .b2_i        (btn[1]),
    .b3_i        (btn[2]),
    .b4_i        (btn[3]),
    .n1_i        (n1),
    .n2_i        (n2),
    .state_o     (state_o),
    .op_o        (op_o),
    .result_o    (result_o),
    .neg_o       (neg_o),
    .res_valid_o (res_valid_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] res;
    logic        neg;
    logic        err;
    logic [1:0]  op;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    logic [31:0] opv;
    opv   = op;
    e.op  = opv[1:0];
    e.err = (a > 99) || (b > 99);
    e.neg = 1'b0;
    e.res = 14'd0;
    if (!e.err) begin
      case (op)
        1: e.res = 14'(a + b);
        2: begin
          e.neg = (a < b);
          e.res = (a < b) ? 14'(b - a) : 14'(a - b);
        end
        3: e.res = 14'(a * b);
        default: e.res = 14'd0;
      endcase
    end
    return e;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input logic [3:0] mask);
    btn = btn & ~mask;
    repeat (10) tick();
  endtask

  // Press, then release; lat = rising edges from release until state changes.
  task automatic release_btn(input logic [3:0] mask, input string name, output int lat);
    logic [1:0] old;
    press_btn(mask);
    old = state_o;
    btn = btn | mask;
    lat = 0;
    while (state_o == old && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (state_o == old) $display("FAIL %s_evt: state stayed %0d after release", name, state_o);
    else passed++;
    $display("txn %s: release mask=%b state %0d->%0d after %0d edges", name, mask, old, state_o, lat);
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s_sb: result %0d produced with empty scoreboard", name, result_o);
      return;
    end
    passed++;
    e = sb.pop_front();
    $display("txn %s: result=%0d neg=%0d err=%0d op=%0d (exp %0d %0d %0d %0d)",
             name, result_o, neg_o, err_o, op_o, e.res, e.neg, e.err, e.op);
    checks++;
    if (result_o !== e.res) $display("FAIL %s_result: got %0d expected %0d", name, result_o, e.res);
    else passed++;
    checks++;
    if (neg_o !== e.neg) $display("FAIL %s_neg: got %0d expected %0d", name, neg_o, e.neg);
    else passed++;
    checks++;
    if (err_o !== e.err) $display("FAIL %s_err: got %0d expected %0d", name, err_o, e.err);
    else passed++;
    checks++;
    if (op_o !== e.op) $display("FAIL %s_op: got %0d expected %0d", name, op_o, e.op);
    else passed++;
  endtask

  // Wait for a 0->1 transition of res_valid_o, then score it.
  task automatic wait_result(input string name);
    logic prev;
    int n;
    prev = res_valid_o;
    n = 0;
    forever begin
      tick();
      n++;
      if (!prev && res_valid_o) break;
      if (n >= 40) break;
      prev = res_valid_o;
    end
    checks++;
    if (!(res_valid_o === 1'b1 && n < 40)) begin
      $display("FAIL %s_timeout: res_valid=%0d after %0d cycles, required 1", name, res_valid_o, n);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      passed++;
      check_sb(name);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (state_o !== 2'd0) $display("FAIL %s_state: got %0d expected 0", name, state_o); else passed++;
    checks++;
    if (op_o !== 2'd0) $display("FAIL %s_op: got %0d expected 0", name, op_o); else passed++;
    checks++;
    if (result_o !== 14'd0) $display("FAIL %s_result: got %0d expected 0", name, result_o); else passed++;
    checks++;
    if (neg_o !== 1'b0) $display("FAIL %s_neg: got %0d expected 0", name, neg_o); else passed++;
    checks++;
    if (res_valid_o !== 1'b0) $display("FAIL %s_rv: got %0d expected 0", name, res_valid_o); else passed++;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL %s_busy: got %0d expected 0", name, busy_o); else passed++;
    checks++;
    if (err_o !== 1'b0) $display("FAIL %s_err: got %0d expected 0", name, err_o); else passed++;
    $display("txn %s: state=%0d op=%0d result=%0d", name, state_o, op_o, result_o);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_power();
    int lat;
    release_btn(4'b1000, "pwr_on", lat);
    checks++;
    if (lat != 6) $display("FAIL pwr_on_latency: got %0d edges expected 6", lat); else passed++;
    checks++;
    if (state_o !== 2'd1) $display("FAIL pwr_on_state: got %0d expected 1", state_o); else passed++;
    release_btn(4'b1000, "pwr_off", lat);
    checks++;
    if (state_o !== 2'd0) $display("FAIL pwr_off_state: got %0d expected 0", state_o); else passed++;
    // Glitch shorter than the debounce window.
    btn[3] = 1'b0;
    repeat (2) tick();
    btn[3] = 1'b1;
    repeat (12) tick();
    checks++;
    if (state_o !== 2'd0) $display("FAIL glitch_state: got %0d expected 0", state_o); else passed++;
    $display("txn glitch: state=%0d", state_o);
    release_btn(4'b1000, "pwr_on2", lat);
    checks++;
    if (state_o !== 2'd1) $display("FAIL pwr_on2_state: got %0d expected 1", state_o); else passed++;
  endtask

  task automatic test_add();
    int lat;
    n1 = 7'd45;
    n2 = 7'd37;
    sb.push_back(model(1, 45, 37));
    release_btn(4'b0001, "add", lat);
    checks++;
    if (lat != 6) $display("FAIL add_latency: got %0d edges expected 6", lat); else passed++;
    checks++;
    if (busy_o !== 1'b1 || res_valid_o !== 1'b0)
      $display("FAIL add_calc: busy=%0d rv=%0d expected 1 0", busy_o, res_valid_o);
    else passed++;
    tick();
    checks++;
    if (res_valid_o !== 1'b1) $display("FAIL add_rv_e2: got %0d expected 1", res_valid_o); else passed++;
    check_sb("add");
    n2 = 7'd55;
    sb.push_back(model(1, 45, 55));
    wait_result("add_recompute");
  endtask

  task automatic test_sub();
    int lat;
    n1 = 7'd12;
    n2 = 7'd30;
    sb.push_back(model(1, 12, 30));
    wait_result("add_new_operands");
    sb.push_back(model(2, 12, 30));
    release_btn(4'b0010, "sub", lat);
    wait_result("sub");
    release_btn(4'b0010, "sub_release", lat);
    checks++;
    if (state_o !== 2'd1 || op_o !== 2'd0 || res_valid_o !== 1'b0 || result_o !== 14'd0)
      $display("FAIL sub_to_idle: state=%0d op=%0d rv=%0d result=%0d expected 1 0 0 0",
               state_o, op_o, res_valid_o, result_o);
    else passed++;
  endtask

  task automatic test_mul();
    int lat;
    int busy_cnt;
    int n;
    n1 = 7'd99;
    n2 = 7'd99;
    sb.push_back(model(3, 99, 99));
    release_btn(4'b0100, "mul", lat);
    busy_cnt = busy_o ? 1 : 0;
    while (busy_o && busy_cnt < 20) begin
      tick();
      if (busy_o) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 7) $display("FAIL mul_busy_cycles: got %0d expected 7", busy_cnt); else passed++;
    checks++;
    if (res_valid_o !== 1'b1) $display("FAIL mul_rv_e8: got %0d expected 1", res_valid_o); else passed++;
    check_sb("mul");
    // Recompute, then abort it with B4.
    press_btn(4'b1000);
    n2 = 7'd98;
    btn[3] = 1'b1;
    tick();
    checks++;
    if (state_o !== 2'd2) $display("FAIL mul_recompute_state: got %0d expected 2", state_o); else passed++;
    repeat (2) tick();
    checks++;
    if (result_o !== 14'd9801 || busy_o !== 1'b1)
      $display("FAIL mul_hold_result: result=%0d busy=%0d expected 9801 1", result_o, busy_o);
    else passed++;
    n = 3;
    while (state_o != 2'd0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 6) $display("FAIL mul_abort_latency: got %0d edges expected 6", n); else passed++;
    checks++;
    if (state_o !== 2'd0 || result_o !== 14'd0 || op_o !== 2'd0 || res_valid_o !== 1'b0)
      $display("FAIL mul_abort_off: state=%0d result=%0d op=%0d rv=%0d expected 0 0 0 0",
               state_o, result_o, op_o, res_valid_o);
    else passed++;
    $display("txn mul_abort: state=%0d result=%0d", state_o, result_o);
  endtask

  task automatic test_err();
    int lat;
    release_btn(4'b1000, "err_pwr_on", lat);
    n1 = 7'd120;
    n2 = 7'd5;
    sb.push_back(model(1, 120, 5));
    release_btn(4'b0001, "err_add", lat);
    wait_result("err_add");
    n1 = 7'd7;
    sb.push_back(model(1, 7, 5));
    wait_result("err_clear");
  endtask

  task automatic test_simultaneous();
    int lat;
    release_btn(4'b0001, "simul_idle", lat);
    checks++;
    if (state_o !== 2'd1) $display("FAIL simul_idle_state: got %0d expected 1", state_o); else passed++;
    sb.push_back(model(1, 7, 5));
    release_btn(4'b0101, "simul_b1b3", lat);
    wait_result("simul_b1b3");
    // Asynchronous reset in the middle of a multiply.
    n1 = 7'd99;
    n2 = 7'd99;
    release_btn(4'b0100, "rst_mul", lat);
    repeat (3) tick();
    checks++;
    if (busy_o !== 1'b1) $display("FAIL rst_mul_busy: got %0d expected 1", busy_o); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_power();
    test_add();
    test_sub();
    test_mul();
    test_err();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
